display_mux_n: RTL
==================

Name: display_mux_n

Overview:
- Parametrised time-multiplexed 7-segment display controller; successor to the fixed 4-digit game display driver.
- Drives N_DIGITS common-anode/cathode digits from a packed hex vector with an internal hex decoder.
- Adds an internal refresh prescaler, frame-synchronised double buffering (no tearing), per-digit blank/blink/decimal point, anti-ghosting dead time and an enable (off) mode.
- Sits between game/control FSMs and the board pins.

Parameters:
- N_DIGITS, 4: number of digits; must be at least 2.
- PRESCALE, 50000: clock cycles per digit slot; must be at least DEAD_CYCLES+1.
- DEAD_CYCLES, 1: cycles at the start of each slot with all digits off.
- BLINK_FRAMES, 64: frames per blink half-period.
- DIGIT_ACTIVE_LOW, 1: 1 means digit[i]=0 selects digit i.
- SEG_ACTIVE_LOW, 1: 1 means seg/dp=0 lights a segment.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = display running; 0 = off (DESLIGADO equivalent)
- digit_data  in  4*N_DIGITS  hex code per digit; digit i = bits [4i+3:4i]
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  N_DIGITS  1 = digit dark
- blink_in  in  N_DIGITS  1 = digit blinks
- load  in  1  1-cycle strobe that captures all *_in / digit_data into staging
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- dp  out  1  decimal point segment
- digit  out  N_DIGITS  digit enables
- frame_tick  out  1  1-cycle pulse when the digit index wraps to 0
- pending  out  1  staging holds data not yet shown

Behaviour:
- Reset (sync, priority over everything):
  - prescaler, digit index, frame counter and blink phase cleared to 0.
  - staging and active registers: data 0, dp 0, blank all 1, blink 0.
  - pending=0, frame_tick=0.
  - digit, seg and dp all driven inactive (polarity per parameters).
- Prescaler counts 0..PRESCALE-1 and wraps. slot_end = (prescaler==PRESCALE-1).
- Digit index:
  - On slot_end, index increments, wrapping N_DIGITS-1 to 0.
  - The wrap cycle is the frame boundary; frame_tick is registered high in the cycle after it.
- Blink:
  - Frame counter counts frame boundaries 0..BLINK_FRAMES-1.
  - On its wrap, blink_phase toggles. blink_phase=1 is the off half.
- Load and double buffering:
  - load=1 captures inputs into staging and sets pending.
  - At a frame boundary with pending=1, active <= staging and pending clears.
  - load coinciding with a frame boundary: active <= the current inputs directly (bypass), staging <= inputs, pending=0.
  - Repeated loads before a boundary: last one wins.
  - Active registers never change mid-frame.
- Output stage (registered, 1-cycle latency from index/prescaler):
  - Let i = index.
  - The digit is off if prescaler < DEAD_CYCLES, or active blank[i]=1, or (active blink[i]=1 and blink_phase=1).
  - Off digit: all digit bits inactive; seg and dp inactive.
  - Otherwise: only digit[i] active; seg = hex decode of active nibble i; dp = active dp[i].
- Hex decode, active-high abcdefg; inverted when SEG_ACTIVE_LOW=1:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- enable=0:
  - Prescaler, index, frame counter and blink_phase held at 0.
  - Outputs registered inactive; frame_tick=0.
  - load and pending still operate; a pending transfer occurs on the first frame boundary after enable returns.
  - On enable 0->1, scanning restarts at digit 0 with a full dead time.
- Reset mid-frame: everything returns to reset values on the next edge; no partial frame completes.
- At most one digit bit is ever active in any cycle.

Test Plan:
- Use N_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1, BLINK_FRAMES=2, active-low polarity throughout.
- Reset then enable=1 with no load -> digit=4'b1111, seg=7'b1111111 forever; frame_tick pulses every 16 cycles; pending=0.
- load with digit_data=16'h4321, blank_in=0 -> pending=1 until the next boundary. The following frame scans digit 0..3, each active for 3 of 4 cycles (1 dead), showing 1,2,3,4. Digit 0: digit=4'b1110, seg=~7'b0110000.
- load 16'h00A8 mid-frame -> current frame keeps showing 4321 with no change; the next frame shows 8,A,0,0.
- blink_in=4'b0010 -> digit 1 is dark for 2 frames and lit for 2 frames, alternately; other digits unaffected.
- load and frame boundary in the same cycle with 16'hFFFF -> the next frame shows F on all digits and pending stays 0.
- enable dropped for 10 cycles mid-slot -> outputs inactive and frame_tick=0. After re-enable, digit 0 becomes active on the 2nd cycle (after dead time). A reset asserted mid-frame restores all reset values on the next edge.

Source files
------------

// File: rtl/display_mux_n.sv
// display_mux_n: time-multiplexed 7-segment display controller.
// Scans N_DIGITS digits from a packed hex vector. Each digit slot opens with a
// dead time that suppresses ghosting. New content is loaded into a staging
// buffer and copied to the active buffer only at a frame boundary, so a
// frame is never drawn from a mix of old and new data.
module display_mux_n #(
    parameter int N_DIGITS         = 4,
    parameter int PRESCALE         = 50000,
    parameter int DEAD_CYCLES      = 1,
    parameter int BLINK_FRAMES     = 64,
    parameter int DIGIT_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   digit_data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     digit,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] DEAD_VAL   = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic DIG_INV = (DIGIT_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

    localparam logic [N_DIGITS-1:0] DIGIT_OFF = {N_DIGITS{DIG_INV}};
    localparam logic [6:0]          SEG_OFF   = {7{SEG_INV}};

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic [4*N_DIGITS-1:0] stg_data, act_data;
    logic [N_DIGITS-1:0]   stg_dp, act_dp;
    logic [N_DIGITS-1:0]   stg_blank, act_blank;
    logic [N_DIGITS-1:0]   stg_blink, act_blink;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  digit_dark;
    logic [3:0]            cur_nibble;
    logic [6:0]            hex_seg;
    logic [N_DIGITS-1:0]   digit_sel;

    assign slot_end   = (presc == PRESC_LAST);
    assign frame_wrap = enable && slot_end && (idx == IDX_LAST);
    assign cur_nibble = act_data[4*idx +: 4];
    assign digit_dark = (presc < DEAD_VAL) || act_blank[idx] ||
                        (act_blink[idx] && blink_phase);

    // Hex nibble to active-high abcdefg pattern (seg[6] = a).
    always_comb begin
        hex_seg = 7'b0000000;
        case (cur_nibble)
            4'h0: hex_seg = 7'b1111110;
            4'h1: hex_seg = 7'b0110000;
            4'h2: hex_seg = 7'b1101101;
            4'h3: hex_seg = 7'b1111001;
            4'h4: hex_seg = 7'b0110011;
            4'h5: hex_seg = 7'b1011011;
            4'h6: hex_seg = 7'b1011111;
            4'h7: hex_seg = 7'b1110000;
            4'h8: hex_seg = 7'b1111111;
            4'h9: hex_seg = 7'b1111011;
            4'hA: hex_seg = 7'b1110111;
            4'hB: hex_seg = 7'b0011111;
            4'hC: hex_seg = 7'b1001110;
            4'hD: hex_seg = 7'b0111101;
            4'hE: hex_seg = 7'b1001111;
            4'hF: hex_seg = 7'b1000111;
            default: hex_seg = 7'b0000000;
        endcase
    end

    // One-hot select of the digit currently being scanned (active-high).
    always_comb begin
        digit_sel      = '0;
        digit_sel[idx] = 1'b1;
    end

    // Scan timing: slot prescaler, digit index, blink frame counter and phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_tick  <= 1'b0;
        end else if (!enable) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            presc      <= slot_end ? '0 : presc + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (frame_wrap) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: load fills staging; the active copy only moves on a frame
    // boundary, taking the live inputs directly when load lands on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_blank <= '1;
            stg_blink <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                stg_data  <= digit_data;
                stg_dp    <= dp_in;
                stg_blank <= blank_in;
                stg_blink <= blink_in;
            end
            if (frame_wrap && load) begin
                act_data  <= digit_data;
                act_dp    <= dp_in;
                act_blank <= blank_in;
                act_blink <= blink_in;
                pending   <= 1'b0;
            end else if (frame_wrap && pending) begin
                act_data  <= stg_data;
                act_dp    <= stg_dp;
                act_blank <= stg_blank;
                act_blink <= stg_blink;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered pin drive; a dark or disabled slot turns every digit off.
    always_ff @(posedge clock) begin
        if (reset || !enable || digit_dark) begin
            digit <= DIGIT_OFF;
            seg   <= SEG_OFF;
            dp    <= SEG_INV;
        end else begin
            digit <= digit_sel ^ DIGIT_OFF;
            seg   <= hex_seg ^ SEG_OFF;
            dp    <= act_dp[idx] ^ SEG_INV;
        end
    end

endmodule
